// File: rtl/spi_pkg.sv
// Shared SPI command definitions: opcodes, frame geometry and master FSM encoding.
// The slave side imports the same opcode constants so both ends agree on the frame.
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 11;
    localparam int DATA_W     = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TURN  = 3'd3;
    localparam logic [2:0] ST_RECV  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Bit 10 duplicates op[1] so the slave sees its write/read select first.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0]        op,
                                                         input logic [DATA_W-1:0] data);
        return {op[1], op[1], op[0], data};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, MSB-first serial out and serial in.
// Load takes priority over shift.
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            sr_d = {sr_q[WIDTH-2:0], ser_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serialises one 11-bit command frame per handshake and,
// for read-data commands, captures the 8-bit reply from MISO.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] LAST_TURN = 4'(RD_LATENCY - 1);
    localparam logic [3:0] LAST_RX   = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_GAP  = 4'(GAP_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  ss_n_q, mosi_q, ready_q, busy_q, rsp_valid_q;
    logic [DATA_W-1:0]     rsp_data_q;
    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_W-1:0]     rx_q;
    logic                  accept, tx_shift, rx_done;

    assign accept   = (state_q == ST_IDLE) && cmd_valid;
    assign tx_shift = (state_d == ST_SHIFT);
    assign rx_done  = (state_q == ST_RECV) && (cnt_q == LAST_RX);

    spi_shift_reg #(.WIDTH(FRAME_BITS)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (tx_shift),
        .din_i   (frame_word(cmd_op, cmd_data)),
        .ser_i   (1'b0),
        .q_o     (tx_q)
    );

    spi_shift_reg #(.WIDTH(DATA_W)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (1'b0),
        .shift_i (state_q == ST_RECV),
        .din_i   ('0),
        .ser_i   (MISO),
        .q_o     (rx_q)
    );

    logic unused_bits;
    assign unused_bits = ^{tx_q[FRAME_BITS-2:0], rx_q[DATA_W-1]};

    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    rd_d    = (cmd_op == OP_RD_DATA);
                end
            end
            ST_START: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = !rd_q ? ST_GAP : ((RD_LATENCY == 0) ? ST_RECV : ST_TURN);
                end
            end
            ST_TURN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_TURN) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_RX) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_GAP) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are flopped from the next state so they change cleanly with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            ss_n_q      <= (state_d == ST_IDLE) || (state_d == ST_GAP);
            mosi_q      <= tx_shift & tx_q[FRAME_BITS-1];
            ready_q     <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= rx_done;
            if (rx_done) begin
                rsp_data_q <= {rx_q[DATA_W-2:0], MISO};
            end
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a default instance and a RD_LATENCY=3/GAP_CYCLES=1
// instance, each with its own MISO reply model and a shared frame monitor.
module tb_spi_master_ctrl;

    localparam int L0 = 2;
    localparam int L1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       sel;

    logic       cmd_ready0, rsp_valid0, busy0, ss_n0, mosi0, miso0;
    logic [7:0] rsp_data0;
    logic       cmd_ready1, rsp_valid1, busy1, ss_n1, mosi1, miso1;
    logic [7:0] rsp_data1;
    logic [7:0] miso_byte0, miso_byte1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_ctrl #(.RD_LATENCY(L0), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
        .busy(busy0), .SS_n(ss_n0), .MOSI(mosi0), .MISO(miso0)
    );

    spi_master_ctrl #(.RD_LATENCY(L1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .busy(busy1), .SS_n(ss_n1), .MOSI(mosi1), .MISO(miso1)
    );

    logic       ss_n_m, mosi_m, busy_m, cmd_ready_m, rsp_valid_m;
    logic [7:0] rsp_data_m;
    assign ss_n_m      = sel ? ss_n1      : ss_n0;
    assign mosi_m      = sel ? mosi1      : mosi0;
    assign busy_m      = sel ? busy1      : busy0;
    assign cmd_ready_m = sel ? cmd_ready1 : cmd_ready0;
    assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid0;
    assign rsp_data_m  = sel ? rsp_data1  : rsp_data0;

    // Slave reply model: byte bit 7 is driven during the first cycle after the turnaround.
    int lc0 = 0, lc1 = 0;
    always @(negedge clk) begin
        if (ss_n0) begin
            lc0 = 0;
            miso0 = 1'b0;
        end else begin
            miso0 = (lc0 >= 12 + L0 && lc0 < 20 + L0) ? miso_byte0[7 - (lc0 - 12 - L0)] : 1'b0;
            lc0++;
        end
        if (ss_n1) begin
            lc1 = 0;
            miso1 = 1'b0;
        end else begin
            miso1 = (lc1 >= 12 + L1 && lc1 < 20 + L1) ? miso_byte1[7 - (lc1 - 12 - L1)] : 1'b0;
            lc1++;
        end
    end

    typedef struct {
        int          low;
        logic [11:0] bits;
    } frame_t;

    frame_t     frames[$];
    int         gaps[$];
    int         rsp_cnt, rsp_bad, low_cnt, gap_run;
    logic       in_frame, first;
    logic [7:0] last_rsp;
    logic [11:0] bits;

    // Frame monitor on the selected instance: low length, first 12 MOSI bits, gap length, responses.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            gap_run  = 0;
        end else if (!ss_n_m) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                low_cnt  = 0;
                bits     = '0;
                if (gap_run > 0) begin gaps.push_back(gap_run); gap_run = 0; end
            end
            if (low_cnt < 12) bits = {bits[10:0], mosi_m};
            low_cnt++;
            if (rsp_valid_m) rsp_bad++;
        end else begin
            first = in_frame;
            if (in_frame) begin
                in_frame = 1'b0;
                frames.push_back('{low_cnt, bits});
            end
            if (rsp_valid_m) begin
                rsp_cnt++;
                if (!first) rsp_bad++;
                last_rsp = rsp_data_m;
            end
            if (busy_m) gap_run++;
            else if (gap_run > 0) begin gaps.push_back(gap_run); gap_run = 0; end
        end
    end

    task automatic clear_mon();
        frames.delete();
        gaps.delete();
        rsp_cnt = 0;
        rsp_bad = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
        int t = 0;
        @(negedge clk);
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready_m && t < 60) begin @(negedge clk); t++; end
        compared++;
        if (cmd_ready_m !== 1'b1) begin
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready_m);
            mismatched++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_m || !ss_n_m) && t < 100) begin @(negedge clk); t++; end
        compared++;
        if (busy_m !== 1'b0) begin
            $display("FAIL idle_timeout: busy=%b required 0", busy_m);
            mismatched++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int idx, input int low,
                               input logic [11:0] exp_bits);
        compared++;
        if (frames[idx].low !== low) begin
            $display("FAIL %s_low: got %0d required %0d", name, frames[idx].low, low);
            mismatched++;
        end
        compared++;
        if (frames[idx].bits !== exp_bits) begin
            $display("FAIL %s_mosi: got %03h required %03h", name, frames[idx].bits, exp_bits);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({ss_n0, mosi0, cmd_ready0, busy0, rsp_valid0} !== 5'b10100) begin
            $display("FAIL reset_ctrl: {ss_n,mosi,ready,busy,rsp_valid}=%b required 10100",
                     {ss_n0, mosi0, cmd_ready0, busy0, rsp_valid0});
            mismatched++;
        end
        compared++;
        if (rsp_data0 !== 8'h00) begin
            $display("FAIL reset_rsp_data: got %02h required 00", rsp_data0);
            mismatched++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({ss_n1, cmd_ready1, busy1} !== 3'b110) begin
            $display("FAIL reset_release: {ss_n,ready,busy}=%b required 110", {ss_n1, cmd_ready1, busy1});
            mismatched++;
        end
    endtask

    task automatic test_write_addr();
        clear_mon();
        send_cmd(2'b00, 8'hFF);
        wait_idle();
        check_frame("wr_addr", 0, 12, 12'h0FF);
        compared++;
        if (gaps[0] !== 2) begin
            $display("FAIL wr_addr_gap: got %0d required 2", gaps[0]);
            mismatched++;
        end
        compared++;
        if (rsp_cnt !== 0) begin
            $display("FAIL wr_addr_rsp: got %0d pulses required 0", rsp_cnt);
            mismatched++;
        end
    endtask

    task automatic test_write_data();
        clear_mon();
        send_cmd(2'b01, 8'hA5);
        wait_idle();
        check_frame("wr_data", 0, 12, 12'h1A5);
        compared++;
        if (rsp_cnt !== 0) begin
            $display("FAIL wr_data_rsp: got %0d pulses required 0", rsp_cnt);
            mismatched++;
        end
    endtask

    task automatic test_read_data();
        clear_mon();
        miso_byte0 = 8'h3C;
        send_cmd(2'b10, 8'hFF);
        wait_idle();
        send_cmd(2'b11, 8'h00);
        wait_idle();
        check_frame("rd_addr", 0, 12, 12'h6FF);
        check_frame("rd_data", 1, 22, 12'h700);
        compared++;
        if (rsp_cnt !== 1 || rsp_bad !== 0) begin
            $display("FAIL rd_rsp_pulse: pulses=%0d misplaced=%0d required 1/0", rsp_cnt, rsp_bad);
            mismatched++;
        end
        compared++;
        if (last_rsp !== 8'h3C) begin
            $display("FAIL rd_rsp_data: got %02h required 3c", last_rsp);
            mismatched++;
        end
        clear_mon();
        send_cmd(2'b00, 8'h11);
        wait_idle();
        compared++;
        if (rsp_data_m !== 8'h3C || rsp_cnt !== 0) begin
            $display("FAIL rsp_retention: data=%02h pulses=%0d required 3c/0", rsp_data_m, rsp_cnt);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[4]      = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [7:0]  dats[4]     = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [11:0] exp_bits[4] = '{12'h012, 12'h134, 12'h656, 12'h078};
        int acc[4];
        int viol = 0;
        clear_mon();
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t = 0;
            cmd_op = ops[i]; cmd_data = dats[i];
            while (!cmd_ready_m && t < 60) begin
                @(negedge clk);
                t++;
                if (cmd_ready_m && busy_m) viol++;
            end
            compared++;
            if (cmd_ready_m !== 1'b1) begin
                $display("FAIL b2b_accept_timeout: cmd %0d ready=%b required 1", i, cmd_ready_m);
                mismatched++;
            end
            acc[i] = cyc;
            @(negedge clk);
            if (cmd_ready_m && busy_m) viol++;
        end
        cmd_valid = 1'b0;
        wait_idle();
        compared++;
        if (viol !== 0) begin
            $display("FAIL b2b_ready_while_busy: got %0d cycles required 0", viol);
            mismatched++;
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (acc[i+1] - acc[i] !== 15) begin
                $display("FAIL b2b_interval: cmd %0d got %0d required 15", i, acc[i+1] - acc[i]);
                mismatched++;
            end
        end
        compared++;
        if (frames.size() !== 4 || gaps.size() !== 4) begin
            $display("FAIL b2b_count: frames=%0d gaps=%0d required 4/4", frames.size(), gaps.size());
            mismatched++;
        end
        for (int i = 0; i < 4; i++) begin
            check_frame("b2b", i, 12, exp_bits[i]);
            compared++;
            if (gaps[i] !== 2) begin
                $display("FAIL b2b_gap: frame %0d got %0d required 2", i, gaps[i]);
                mismatched++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        miso_byte0 = 8'hFF;
        send_cmd(2'b11, 8'h00);
        repeat (6) @(negedge clk);
        compared++;
        if ({ss_n0, busy0} !== 2'b01) begin
            $display("FAIL mid_frame_pre: {ss_n,busy}=%b required 01", {ss_n0, busy0});
            mismatched++;
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({ss_n0, busy0, cmd_ready0, rsp_valid0} !== 4'b1010) begin
            $display("FAIL mid_frame_reset: {ss_n,busy,ready,rsp_valid}=%b required 1010",
                     {ss_n0, busy0, cmd_ready0, rsp_valid0});
            mismatched++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        compared++;
        if (rsp_cnt !== 0 || frames.size() !== 0) begin
            $display("FAIL mid_frame_abort: pulses=%0d frames=%0d required 0/0", rsp_cnt, frames.size());
            mismatched++;
        end
        send_cmd(2'b00, 8'h00);
        wait_idle();
        check_frame("post_reset", 0, 12, 12'h000);
    endtask

    task automatic test_param_sweep();
        sel = 1'b1;
        miso_byte1 = 8'h81;
        clear_mon();
        send_cmd(2'b11, 8'h00);
        wait_idle();
        check_frame("sweep_rd", 0, 23, 12'h700);
        compared++;
        if (last_rsp !== 8'h81 || rsp_cnt !== 1 || rsp_bad !== 0) begin
            $display("FAIL sweep_rsp: data=%02h pulses=%0d misplaced=%0d required 81/1/0",
                     last_rsp, rsp_cnt, rsp_bad);
            mismatched++;
        end
        compared++;
        if (gaps[0] !== 1) begin
            $display("FAIL sweep_gap: got %0d required 1", gaps[0]);
            mismatched++;
        end
        sel = 1'b0;
    endtask

    initial begin
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        sel        = 1'b0;
        miso_byte0 = 8'h00;
        miso_byte1 = 8'h00;
        test_reset();
        test_write_addr();
        test_write_data();
        test_read_data();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that sits directly upstream of the SPI slave + single-port RAM top.
- Accepts one 10-bit RAM command per valid/ready handshake (2-bit opcode + 8-bit address/data) and serialises it as a slave frame on SS_n/MOSI.
- For read-data commands it holds SS_n low, captures the 8-bit reply from MISO and returns it on a one-cycle response strobe.
- Runs on the same clock as the slave, so no clock-domain crossing.

Parameters:
- RD_LATENCY, 2: idle cycles between the last MOSI bit of a read-data frame and the first MISO sample (slave RAM read plus load turnaround).
- GAP_CYCLES, 2: minimum cycles SS_n stays high between frames; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  in  8  address or write data.
- rsp_valid  out  1  one-cycle pulse: rsp_data holds read byte.
- rsp_data  out  8  byte captured from MISO.
- busy  out  1  high from command accept until return to IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async assert, sync release):
  - SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0x00.
  - Bit and cycle counters clear; state returns to IDLE.
- Reset asserted mid-frame: SS_n rises immediately and no rsp_valid is produced. The slave observes SS_n high and aborts the frame.
- Handshake:
  - A command is accepted on a rising edge when cmd_valid && cmd_ready.
  - {cmd_op, cmd_data} are registered into an 11-bit frame word: {cmd_op[1], cmd_op[1], cmd_op[0], cmd_data[7:0]}. Bit 10 is the slave's write/read select.
  - cmd_ready=1 only in IDLE. cmd_valid while busy is ignored, and cmd_* need not be held after acceptance.
- States:
  - IDLE: SS_n=1, MOSI=0. On accept, go to START.
  - START (1 cycle): SS_n=0, MOSI=0. This is the slave's IDLE to CHK_CMD cycle. Go to SHIFT.
  - SHIFT (11 cycles): SS_n=0. MOSI = frame word MSB first, bit 10 first, one bit per cycle, driven from a register. At the 11th bit:
    - op=11: go to TURN.
    - otherwise: go to GAP.
  - TURN (RD_LATENCY cycles): SS_n=0, MOSI=0. Go to RECV.
  - RECV (8 cycles): SS_n=0, MOSI=0. MISO is sampled at the rising edge ending each cycle and shifted in MSB first. After the 8th sample:
    - rsp_data is updated with the full byte.
    - rsp_valid=1 for exactly the next cycle, which is the first GAP cycle.
    - Go to GAP.
  - GAP (GAP_CYCLES): SS_n=1, MOSI=0. Go to IDLE.
- Frame lengths with SS_n low:
  - Ops 00, 01, 10: 12 cycles.
  - Op 11: 12 + RD_LATENCY + 8 cycles (22 at default).
- Command-to-command spacing: minimum accept-to-accept interval is 12 + GAP_CYCLES + 1 (IDLE) cycles for non-read frames.
- Data retention: rsp_data holds its value until the next read-data completion. rsp_valid is never asserted for ops 00, 01, 10.
- Outputs: all outputs are registered, with no combinational path from MISO or cmd_* to any output.
- Sequencing: the master does not enforce the slave's required command order (read-addr before read-data). It sends whatever it is given.

Decomposition:
- Package spi_pkg, holding:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_BITS=11, DATA_W=8;
  - state encoding (IDLE, START, SHIFT, TURN, RECV, GAP).
  - The slave should reuse the opcode constants from this package.
- One sub-module, spi_shift_reg: parallel-load, serial-out-MSB / serial-in-MSB shift register, width parameter, with load/shift enables.
  - Instantiated twice: 11-bit TX and 8-bit RX.
- FSM and counters stay in spi_master_ctrl.

Test Plan:
- Write address: cmd_op=00, cmd_data=0xFF.
  - Expect SS_n low for 12 cycles.
  - Expect MOSI = 0 (START), then 0,0,0,1,1,1,1,1,1,1,1.
  - Expect SS_n high ≥2 cycles and no rsp_valid.
  - The slave then holds write address 0xFF.
- Write data: op=01, data=0xA5.
  - Expect MOSI bits 0,0,1,1,0,1,0,0,1,0,1.
  - A subsequent read-addr 0xFF plus read-data through the real slave/RAM returns rsp_data=0xA5 with a single rsp_valid pulse.
- Read data against a MISO model driving 0x3C starting RD_LATENCY cycles after the last MOSI bit.
  - Expect SS_n low 22 cycles.
  - Expect rsp_valid exactly 1 cycle, coincident with the first SS_n-high cycle, and rsp_data=0x3C.
- Back-to-back: hold cmd_valid high with four queued commands.
  - Expect cmd_ready low while busy.
  - Expect each command accepted once, in order, with SS_n high exactly GAP_CYCLES cycles between frames.
- Reset mid-frame: assert rst at SHIFT bit 5 of a read-data frame.
  - Expect SS_n=1, busy=0, cmd_ready=1 in the same cycle, and no rsp_valid.
  - A new write-addr 0x00 after release is framed correctly (MOSI all 0 for 11 bits).
- Parameter sweep at RD_LATENCY=3, GAP_CYCLES=1 with MISO model 0x81.
  - Expect rsp_data=0x81, read frame low for 23 cycles, gap of 1 cycle.
